// File: rtl/ddr_pkg.sv
// Shared DDR serializer definitions: mode codes, sequencer states and the
// state-to-mode mapping used by the transmit sequencer.
package ddr_pkg;

  localparam int WORD_CNT_W = 5;

  typedef enum logic [3:0] {
    MODE_PRE_SPECIAL = 4'b0000,
    MODE_ADDR        = 4'b0001,
    MODE_ONE         = 4'b0010,
    MODE_ZEROS       = 4'b0011,
    MODE_PARITY      = 4'b0100,
    MODE_CCC         = 4'b0101,
    MODE_ZERO        = 4'b0110,
    MODE_DATA        = 4'b0111,
    MODE_TOKEN       = 4'b1100,
    MODE_CRC         = 4'b1101,
    MODE_EXIT        = 4'b1110,
    MODE_RESTART     = 4'b1111
  } tx_mode_e;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CMD_PRE,
    ST_CMD_RNW,
    ST_CMD_ZEROS,
    ST_CMD_ADDR,
    ST_CMD_PAR,
    ST_D_PRE1,
    ST_D_PRE0,
    ST_D_B1,
    ST_D_B2,
    ST_D_PAR,
    ST_C_PRE,
    ST_C_TOKEN,
    ST_C_VAL,
    ST_END_PAT
  } seq_state_e;

  function automatic tx_mode_e mode_for(seq_state_e st, logic rnw, logic restart);
    tx_mode_e m;
    case (st)
      ST_CMD_RNW:           m = rnw ? MODE_ONE : MODE_ZERO;
      ST_CMD_ZEROS:         m = MODE_ZEROS;
      ST_CMD_ADDR:          m = MODE_ADDR;
      ST_CMD_PAR, ST_D_PAR: m = MODE_PARITY;
      ST_D_PRE1:            m = MODE_ONE;
      ST_D_PRE0:            m = MODE_ZERO;
      ST_D_B1, ST_D_B2:     m = MODE_DATA;
      ST_C_TOKEN:           m = MODE_TOKEN;
      ST_C_VAL:             m = MODE_CRC;
      ST_END_PAT:           m = restart ? MODE_RESTART : MODE_EXIT;
      default:              m = MODE_PRE_SPECIAL;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/ddr_tx_sequencer.sv
// DDR transmit frame sequencer: steps the serializer through command, data
// and CRC phases, one mode per mode-complete pulse, with abort and restart.
module ddr_tx_sequencer
  import ddr_pkg::*;
(
  input  logic       i_sys_clk,
  input  logic       i_sys_rst,
  input  logic       i_frame_start,
  input  logic       i_rnw,
  input  logic [4:0] i_word_count,
  input  logic       i_end_restart,
  input  logic       i_abort,
  input  logic       i_tx_mode_done,
  output logic       o_tx_en,
  output logic [3:0] o_tx_mode,
  output logic       o_regf_rd_en,
  output logic       o_crc_init,
  output logic       o_busy,
  output logic       o_frame_done,
  output logic       o_aborted
);

  seq_state_e            state_q, state_d;
  tx_mode_e              tx_mode_q, tx_mode_d;
  logic [WORD_CNT_W-1:0] word_cnt_q, word_cnt_d, word_cnt_dec;
  logic                  tx_en_q, tx_en_d;
  logic                  rnw_q, rnw_d;
  logic                  restart_q, restart_d;
  logic                  rd_en_q, rd_en_d;
  logic                  crc_init_q, crc_init_d;
  logic                  done_q, done_d;
  logic                  aborted_q, aborted_d;

  assign word_cnt_dec = word_cnt_q - 5'd1;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned and infers a latch.
    state_d    = state_q;
    tx_mode_d  = tx_mode_q;
    word_cnt_d = word_cnt_q;
    tx_en_d    = tx_en_q;
    rnw_d      = rnw_q;
    restart_d  = restart_q;
    rd_en_d    = 1'b0;
    crc_init_d = 1'b0;
    done_d     = 1'b0;
    aborted_d  = 1'b0;

    if (state_q == ST_IDLE) begin
      if (i_frame_start) begin
        state_d    = ST_CMD_PRE;
        tx_mode_d  = MODE_PRE_SPECIAL;
        tx_en_d    = 1'b1;
        crc_init_d = 1'b1;
        rnw_d      = i_rnw;
        restart_d  = i_end_restart;
        word_cnt_d = (i_word_count == 5'd0) ? 5'd1 : i_word_count;
      end
    end else if (i_abort) begin
      state_d   = ST_IDLE;
      tx_mode_d = MODE_PRE_SPECIAL;
      tx_en_d   = 1'b0;
      aborted_d = 1'b1;
    end else if (i_tx_mode_done) begin
      case (state_q)
        ST_CMD_PRE:   state_d = ST_CMD_RNW;
        ST_CMD_RNW:   state_d = ST_CMD_ZEROS;
        ST_CMD_ZEROS: state_d = ST_CMD_ADDR;
        ST_CMD_ADDR:  state_d = ST_CMD_PAR;
        ST_CMD_PAR:   state_d = rnw_q ? ST_IDLE : ST_D_PRE1;
        ST_D_PRE1:    state_d = ST_D_PRE0;
        ST_D_PRE0:    state_d = ST_D_B1;
        ST_D_B1: begin
          state_d = ST_D_B2;
          rd_en_d = 1'b1;
        end
        ST_D_B2: begin
          state_d = ST_D_PAR;
          rd_en_d = 1'b1;
        end
        ST_D_PAR: begin
          word_cnt_d = word_cnt_dec;
          state_d    = (word_cnt_dec != 5'd0) ? ST_D_PRE1 : ST_C_PRE;
        end
        ST_C_PRE:     state_d = ST_C_TOKEN;
        ST_C_TOKEN:   state_d = ST_C_VAL;
        ST_C_VAL:     state_d = ST_END_PAT;
        default:      state_d = ST_IDLE;
      endcase

      if (state_d == ST_IDLE) begin
        tx_en_d   = 1'b0;
        done_d    = 1'b1;
        tx_mode_d = MODE_PRE_SPECIAL;
      end else begin
        tx_mode_d = mode_for(state_d, rnw_q, restart_q);
      end
    end
  end

  always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
    if (!i_sys_rst) begin
      state_q    <= ST_IDLE;
      tx_mode_q  <= MODE_PRE_SPECIAL;
      word_cnt_q <= '0;
      tx_en_q    <= 1'b0;
      rnw_q      <= 1'b0;
      restart_q  <= 1'b0;
      rd_en_q    <= 1'b0;
      crc_init_q <= 1'b0;
      done_q     <= 1'b0;
      aborted_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking updates so every register samples pre-edge values.
      state_q    <= state_d;
      tx_mode_q  <= tx_mode_d;
      word_cnt_q <= word_cnt_d;
      tx_en_q    <= tx_en_d;
      rnw_q      <= rnw_d;
      restart_q  <= restart_d;
      rd_en_q    <= rd_en_d;
      crc_init_q <= crc_init_d;
      done_q     <= done_d;
      aborted_q  <= aborted_d;
    end
  end

  assign o_tx_en      = tx_en_q;
  assign o_tx_mode    = tx_mode_q;
  assign o_regf_rd_en = rd_en_q;
  assign o_crc_init   = crc_init_q;
  assign o_busy       = (state_q != ST_IDLE);
  assign o_frame_done = done_q;
  assign o_aborted    = aborted_q;

endmodule

// File: tb/tb_ddr_tx_sequencer.sv
// Directed bench for ddr_tx_sequencer: full write/read frames, busy-time start,
// zero word count, abort against a done pulse, and reset in the CRC phase.
module tb_ddr_tx_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       i_frame_start, i_rnw, i_end_restart, i_abort, i_tx_mode_done;
  logic [4:0] i_word_count;
  logic       o_tx_en, o_regf_rd_en, o_crc_init, o_busy, o_frame_done, o_aborted;
  logic [3:0] o_tx_mode;

  int vectors     = 0;
  int miscompares = 0;
  int rd_cnt      = 0;
  int done_cnt    = 0;
  int ab_cnt      = 0;

  logic [3:0] exp_modes[$];

  ddr_tx_sequencer dut (
    .i_sys_clk     (clk),
    .i_sys_rst     (rst_n),
    .i_frame_start (i_frame_start),
    .i_rnw         (i_rnw),
    .i_word_count  (i_word_count),
    .i_end_restart (i_end_restart),
    .i_abort       (i_abort),
    .i_tx_mode_done(i_tx_mode_done),
    .o_tx_en       (o_tx_en),
    .o_tx_mode     (o_tx_mode),
    .o_regf_rd_en  (o_regf_rd_en),
    .o_crc_init    (o_crc_init),
    .o_busy        (o_busy),
    .o_frame_done  (o_frame_done),
    .o_aborted     (o_aborted)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (o_regf_rd_en) rd_cnt++;
    if (o_frame_done) done_cnt++;
    if (o_aborted)    ab_cnt++;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] all_outs();
    return {7'd0, o_tx_en, o_tx_mode, o_regf_rd_en, o_crc_init, o_busy, o_frame_done, o_aborted};
  endfunction

  task automatic start_frame(input logic rnw, input logic [4:0] wc, input logic rst_pat);
    @(negedge clk);
    i_frame_start = 1'b1;
    i_rnw         = rnw;
    i_word_count  = wc;
    i_end_restart = rst_pat;
    @(negedge clk);
    i_frame_start = 1'b0;
  endtask

  task automatic step_done(input int n);
    for (int i = 0; i < n; i++) begin
      repeat (3) @(negedge clk);
      i_tx_mode_done = 1'b1;
      @(negedge clk);
      i_tx_mode_done = 1'b0;
    end
  endtask

  // Runs one frame against exp_modes with a done pulse every 4 cycles.
  task automatic run_frame(input string tag, input logic rnw, input logic [4:0] wc,
                           input logic rst_pat, input int exp_rd, input bit busy_start);
    int rd_base   = rd_cnt;
    int done_base = done_cnt;
    start_frame(rnw, wc, rst_pat);
    check({tag, " start mode"}, 16'(o_tx_mode), 16'(exp_modes[0]));
    check({tag, " start tx_en"}, 16'(o_tx_en), 16'd1);
    check({tag, " start crc_init"}, 16'(o_crc_init), 16'd1);
    check({tag, " start busy"}, 16'(o_busy), 16'd1);
    for (int k = 1; k <= exp_modes.size(); k++) begin
      for (int h = 0; h < 3; h++) begin
        if (busy_start && k == 3 && h == 0) begin
          i_frame_start = 1'b1;
          i_rnw         = ~rnw;
          i_word_count  = 5'd7;
          i_end_restart = ~rst_pat;
        end
        @(negedge clk);
        i_frame_start = 1'b0;
        check({tag, " hold tx_en"}, 16'(o_tx_en), 16'd1);
        check({tag, " hold mode"}, 16'(o_tx_mode), 16'(exp_modes[k-1]));
      end
      i_tx_mode_done = 1'b1;
      @(negedge clk);
      i_tx_mode_done = 1'b0;
      if (k < exp_modes.size()) begin
        check($sformatf("%s mode[%0d]", tag, k), 16'(o_tx_mode), 16'(exp_modes[k]));
        check({tag, " tx_en"}, 16'(o_tx_en), 16'd1);
        check({tag, " crc_init idle"}, 16'(o_crc_init), 16'd0);
      end
    end
    check({tag, " end frame_done"}, 16'(o_frame_done), 16'd1);
    check({tag, " end tx_en"}, 16'(o_tx_en), 16'd0);
    check({tag, " end busy"}, 16'(o_busy), 16'd0);
    @(negedge clk);
    check({tag, " frame_done width"}, 16'(o_frame_done), 16'd0);
    check({tag, " rd_en pulses"}, 16'(rd_cnt - rd_base), 16'(exp_rd));
    check({tag, " frame_done pulses"}, 16'(done_cnt - done_base), 16'd1);
  endtask

  initial begin
    int rd_base, done_base, ab_base;
    rst_n = 1'b0;
    i_frame_start = 1'b0; i_rnw = 1'b0; i_word_count = 5'd0;
    i_end_restart = 1'b0; i_abort = 1'b0; i_tx_mode_done = 1'b0;
    repeat (2) @(negedge clk);
    check("reset outputs", all_outs(), 16'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("first cycle after release", all_outs(), 16'd0);

    // Single-word write, exit pattern.
    exp_modes = {4'h0, 4'h6, 4'h3, 4'h1, 4'h4, 4'h2, 4'h6, 4'h7, 4'h7, 4'h4,
                 4'h0, 4'hC, 4'hD, 4'hE};
    run_frame("wr1", 1'b0, 5'd1, 1'b0, 2, 1'b0);

    // Three-word write, restart pattern.
    exp_modes = {4'h0, 4'h6, 4'h3, 4'h1, 4'h4};
    repeat (3) exp_modes = {exp_modes, 4'h2, 4'h6, 4'h7, 4'h7, 4'h4};
    exp_modes = {exp_modes, 4'h0, 4'hC, 4'hD, 4'hF};
    run_frame("wr3", 1'b0, 5'd3, 1'b1, 6, 1'b0);

    // Read: command phase only.
    exp_modes = {4'h0, 4'h2, 4'h3, 4'h1, 4'h4};
    run_frame("rd", 1'b1, 5'd5, 1'b0, 0, 1'b0);

    // Zero count runs as one word; a start while busy is ignored.
    exp_modes = {4'h0, 4'h6, 4'h3, 4'h1, 4'h4, 4'h2, 4'h6, 4'h7, 4'h7, 4'h4,
                 4'h0, 4'hC, 4'hD, 4'hE};
    run_frame("wr0", 1'b0, 5'd0, 1'b0, 2, 1'b1);

    // Abort in D_B2 on the same cycle as the done pulse.
    rd_base = rd_cnt; done_base = done_cnt; ab_base = ab_cnt;
    start_frame(1'b0, 5'd1, 1'b0);
    step_done(8);
    check("abort pre mode", 16'(o_tx_mode), 16'h7);
    i_tx_mode_done = 1'b1;
    i_abort        = 1'b1;
    @(negedge clk);
    i_tx_mode_done = 1'b0;
    i_abort        = 1'b0;
    check("abort outputs", all_outs(), 16'h0001);
    @(negedge clk);
    check("abort pulse width", 16'(o_aborted), 16'd0);
    check("abort rd_en pulses", 16'(rd_cnt - rd_base), 16'd1);
    check("abort frame_done pulses", 16'(done_cnt - done_base), 16'd0);
    check("abort pulses", 16'(ab_cnt - ab_base), 16'd1);

    // Done and abort are ignored while idle.
    i_tx_mode_done = 1'b1;
    i_abort        = 1'b1;
    @(negedge clk);
    i_tx_mode_done = 1'b0;
    i_abort        = 1'b0;
    check("idle ignore", all_outs(), 16'd0);

    // Reset asserted during the CRC value mode.
    start_frame(1'b0, 5'd1, 1'b0);
    step_done(12);
    check("crc mode before reset", 16'(o_tx_mode), 16'hD);
    #2 rst_n = 1'b0;
    #1 check("async reset outputs", all_outs(), 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post reset quiet", all_outs(), 16'd0);

    exp_modes = {4'h0, 4'h6, 4'h3, 4'h1, 4'h4};
    repeat (2) exp_modes = {exp_modes, 4'h2, 4'h6, 4'h7, 4'h7, 4'h4};
    exp_modes = {exp_modes, 4'h0, 4'hC, 4'hD, 4'hE};
    run_frame("wr2 after reset", 1'b0, 5'd2, 1'b0, 4, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ddr_tx_sequencer.md
DDR_TX_SEQUENCER -- requirements
Module: ddr_tx_sequencer

Interface
REQ-001 SHALL have port i_sys_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-002 SHALL have port i_sys_rst, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port i_frame_start, input, 1 bit: one-cycle request to send a frame; sampled only in IDLE.
REQ-004 SHALL have port i_rnw, input, 1 bit: 1 = read frame, 0 = write frame; captured at start.
REQ-005 SHALL have port i_word_count, input, 5 bits: number of data words (1..31) in a write frame; captured at start.
REQ-006 SHALL have port i_end_restart, input, 1 bit: 1 = end with restart pattern, 0 = end with exit pattern; captured at start.
REQ-007 SHALL have port i_abort, input, 1 bit: synchronous abort of the frame in progress.
REQ-008 SHALL have port i_tx_mode_done, input, 1 bit: mode-complete pulse from the DDR serializer.
REQ-009 SHALL have port o_tx_en, output, 1 bit: serializer enable.
REQ-010 SHALL have port o_tx_mode, output, 4 bits: serializer mode code.
REQ-011 SHALL have port o_regf_rd_en, output, 1 bit: one-cycle pulse that advances the register-file byte pointer.
REQ-012 SHALL have port o_crc_init, output, 1 bit: one-cycle pulse that clears the CRC-5 accumulator.
REQ-013 SHALL have port o_busy, output, 1 bit: high whenever the FSM is not in IDLE.
REQ-014 SHALL have port o_frame_done, output, 1 bit: one-cycle completion pulse.
REQ-015 SHALL have port o_aborted, output, 1 bit: one-cycle pulse marking an abort.

Function
REQ-016 SHALL use these mode codes: PRE_SPECIAL=0000, ADDR=0001, ONE=0010, ZEROS=0011, PARITY=0100, CCC=0101, ZERO=0110, DATA=0111, TOKEN=1100, CRC=1101, EXIT=1110, RESTART=1111.
REQ-017 SHALL implement states IDLE, CMD_PRE, CMD_RNW, CMD_ZEROS, CMD_ADDR, CMD_PAR, D_PRE1, D_PRE0, D_B1, D_B2, D_PAR, C_PRE, C_TOKEN, C_VAL, END_PAT.
REQ-018 SHALL drive o_tx_mode per state: CMD_PRE/C_PRE->0000; CMD_RNW->0010 if rnw, else 0110; CMD_ZEROS->0011; CMD_ADDR->0001; CMD_PAR/D_PAR->0100; D_PRE1->0010; D_PRE0->0110; D_B1/D_B2->0111; C_TOKEN->1100; C_VAL->1101; END_PAT->1111 if restart, else 1110.
REQ-019 SHALL advance exactly one state on each cycle with i_tx_mode_done=1, and hold state otherwise; the new o_tx_mode is registered and valid on the cycle after the done pulse.
REQ-020 SHALL leave IDLE when i_frame_start=1: go to CMD_PRE, set o_tx_en=1, pulse o_crc_init, and load word_cnt=i_word_count.
REQ-021 SHALL treat i_word_count=0 on a write as 1.
REQ-022 SHALL hold o_tx_en=1 continuously from CMD_PRE until the frame ends, with no gaps between modes.
REQ-023 SHALL, on a read frame, go from CMD_PAR (done) to IDLE, pulse o_frame_done, and drop o_tx_en; no data or CRC words are sent.
REQ-024 SHALL, on a write frame, go from CMD_PAR to D_PRE1, then D_PRE0, D_B1, D_B2, D_PAR.
REQ-025 SHALL, at D_PAR done, decrement word_cnt; if the result is nonzero go to D_PRE1, otherwise go to C_PRE.
REQ-026 SHALL pulse o_regf_rd_en on the done cycle of D_B1 and of D_B2 (exactly 2*word_count pulses per write).
REQ-027 SHALL go C_PRE->C_TOKEN->C_VAL->END_PAT; END_PAT done -> IDLE with a one-cycle o_frame_done and o_tx_en=0 on that same cycle.
REQ-028 SHALL, on i_abort=1 in any non-IDLE state, go to IDLE next cycle, set o_tx_en=0, pulse o_aborted, and not pulse o_frame_done; abort takes priority over a simultaneous i_tx_mode_done.
REQ-029 SHALL ignore i_frame_start while busy, and ignore i_tx_mode_done and i_abort while in IDLE.

Reset
REQ-030 SHALL, on reset assertion, asynchronously force state=IDLE, o_tx_en=0, o_tx_mode=0000, word_cnt=0, and o_regf_rd_en, o_crc_init, o_busy, o_frame_done, o_aborted all 0.
REQ-031 SHALL emit no pulses on the first cycle after reset release.

Structure
REQ-032 SHALL take the mode-code constants and the state enumeration from a shared package ddr_pkg, which the serializer also uses.
REQ-033 SHALL be a single module with no sub-modules; the 5-bit word counter is inline.

Verification
REQ-034 SHALL cover a write with word_count=1 and done pulses every 4 cycles: the mode sequence is 0000,0110,0011,0001,0100,0010,0110,0111,0111,0100,0000,1100,1101,1110, with 2 rd_en pulses and 1 frame_done.
REQ-035 SHALL cover a write with word_count=3 and restart=1: 3 data-word groups, 6 rd_en pulses, and final mode 1111.
REQ-036 SHALL cover a read: the mode sequence is 0000,0010,0011,0001,0100, then frame_done and tx_en=0, with no rd_en pulses.
REQ-037 SHALL cover abort asserted in D_B2 on the same cycle as i_tx_mode_done: IDLE next cycle, o_aborted=1, no rd_en pulse, no frame_done.
REQ-038 SHALL cover reset asserted mid-CRC: all outputs are 0 immediately; a new i_frame_start after release runs a full frame correctly.
REQ-039 SHALL cover i_frame_start while busy and word_count=0: the busy-time start is ignored, and the zero count runs as one word.
